// File: rtl/bomb_pkg.sv
// Shared definitions for the bomb subsystem: slot state encoding, default map size
// and the tile index helper used by both the player and bomb blocks.
package bomb_pkg;

    localparam int HMAXTILE_DEFAULT = 9;
    localparam int VMAXTILE_DEFAULT = 5;

    typedef enum logic [1:0] {
        SLOT_IDLE  = 2'd0,
        SLOT_ARMED = 2'd1,
        SLOT_BLAST = 2'd2
    } slot_state_e;

    // Row-major tile index, computed at 8 bits so out-of-range coordinates never alias low.
    function automatic logic [7:0] tile_index(input logic [3:0] h, input logic [3:0] v,
                                              input int hmax);
        logic [7:0] row;
        row = 8'(hmax + 1);
        return row * {4'd0, v} + {4'd0, h};
    endfunction

endpackage

// File: rtl/bomb_slot.sv
// One tracked bomb: IDLE -> ARMED (fuse) -> BLAST (window) -> IDLE.
// A chain trigger while ARMED cuts the fuse short; state is exposed for observation.
module bomb_slot
    import bomb_pkg::*;
#(
    parameter int CNTW         = 27,
    parameter int FUSE_CYCLES  = 2**26,
    parameter int BLAST_CYCLES = 2**24
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        alloc,
    input  logic [3:0]  alloc_h,
    input  logic [3:0]  alloc_v,
    input  logic        chain,
    output slot_state_e state,
    output logic [3:0]  h,
    output logic [3:0]  v
);

    localparam logic [CNTW-1:0] FUSE_LAST  = CNTW'(FUSE_CYCLES - 1);
    localparam logic [CNTW-1:0] BLAST_LAST = CNTW'(BLAST_CYCLES - 1);

    logic [CNTW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= SLOT_IDLE;
            cnt   <= '0;
            h     <= '0;
            v     <= '0;
        end else begin
            case (state)
                SLOT_IDLE: begin
                    cnt <= '0;
                    if (alloc) begin
                        state <= SLOT_ARMED;
                        h     <= alloc_h;
                        v     <= alloc_v;
                    end
                end
                // Fuse expiry and chain trigger in the same cycle collapse into one entry.
                SLOT_ARMED: begin
                    if (chain || cnt == FUSE_LAST) begin
                        state <= SLOT_BLAST;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CNTW'(1);
                    end
                end
                SLOT_BLAST: begin
                    if (cnt == BLAST_LAST) begin
                        state <= SLOT_IDLE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CNTW'(1);
                    end
                end
                default: begin
                    state <= SLOT_IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/bomb_manager.sv
// Bomb pool for two players: allocates slots on place requests, drives the bomb and
// blast tile maps, propagates chain reactions and reports per-player hits.
module bomb_manager
    import bomb_pkg::*;
#(
    parameter int HMAXTILE     = HMAXTILE_DEFAULT,
    parameter int VMAXTILE     = VMAXTILE_DEFAULT,
    parameter int SLOTS        = 8,
    parameter int FUSE_CYCLES  = 2**26,
    parameter int BLAST_CYCLES = 2**24,
    parameter int CNTW         = 27,
    localparam int TILES       = (HMAXTILE + 1) * (VMAXTILE + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             placeA,
    input  logic [3:0]       ah,
    input  logic [3:0]       av,
    input  logic             placeB,
    input  logic [3:0]       bh,
    input  logic [3:0]       bv,
    input  logic [TILES-1:0] walkAble,
    output logic [TILES-1:0] bombMap,
    output logic [TILES-1:0] blastMap,
    output logic             hitA,
    output logic             hitB,
    output logic             dropped
);

    localparam logic [7:0] ROW   = 8'(HMAXTILE + 1);
    localparam logic [3:0] HMAX4 = 4'(HMAXTILE);
    localparam logic [3:0] VMAX4 = 4'(VMAXTILE);

    // Shifting a one avoids indexing the map with an index wider than it needs.
    function automatic logic [TILES-1:0] onehot(input logic [7:0] idx);
        return TILES'(1) << idx;
    endfunction

    function automatic logic bit_at(input logic [TILES-1:0] vec, input logic [7:0] idx);
        return |(vec & onehot(idx));
    endfunction

    slot_state_e      slot_state [SLOTS];
    logic [3:0]       slot_h     [SLOTS];
    logic [3:0]       slot_v     [SLOTS];
    logic [7:0]       slot_idx   [SLOTS];
    logic [SLOTS-1:0] alloc_a;
    logic [SLOTS-1:0] alloc_b;
    logic [SLOTS-1:0] chain;
    logic [TILES-1:0] occ_map;

    for (genvar i = 0; i < SLOTS; i++) begin : g_slot
        assign slot_idx[i] = tile_index(slot_h[i], slot_v[i], HMAXTILE);
        assign chain[i]    = bit_at(blastMap, slot_idx[i]);

        bomb_slot #(
            .CNTW        (CNTW),
            .FUSE_CYCLES (FUSE_CYCLES),
            .BLAST_CYCLES(BLAST_CYCLES)
        ) u_slot (
            .clk    (clk),
            .rst_n  (rst_n),
            .alloc  (alloc_a[i] | alloc_b[i]),
            .alloc_h(alloc_a[i] ? ah : bh),
            .alloc_v(alloc_a[i] ? av : bv),
            .chain  (chain[i]),
            .state  (slot_state[i]),
            .h      (slot_h[i]),
            .v      (slot_v[i])
        );
    end

    always_comb begin
        bombMap  = '0;
        blastMap = '0;
        occ_map  = '0;
        for (int i = 0; i < SLOTS; i++) begin
            if (slot_state[i] == SLOT_ARMED) bombMap |= onehot(slot_idx[i]);
            if (slot_state[i] != SLOT_IDLE)  occ_map |= onehot(slot_idx[i]);
            if (slot_state[i] == SLOT_BLAST) begin
                blastMap |= onehot(slot_idx[i]);
                if (slot_h[i] != 4'd0 && bit_at(walkAble, slot_idx[i] - 8'd1))
                    blastMap |= onehot(slot_idx[i] - 8'd1);
                if (slot_h[i] < HMAX4 && bit_at(walkAble, slot_idx[i] + 8'd1))
                    blastMap |= onehot(slot_idx[i] + 8'd1);
                if (slot_v[i] != 4'd0 && bit_at(walkAble, slot_idx[i] - ROW))
                    blastMap |= onehot(slot_idx[i] - ROW);
                if (slot_v[i] < VMAX4 && bit_at(walkAble, slot_idx[i] + ROW))
                    blastMap |= onehot(slot_idx[i] + ROW);
            end
        end
    end

    logic [7:0] idx_a;
    logic [7:0] idx_b;
    logic       a_in_range;
    logic       b_in_range;
    logic       want_a;
    logic       want_b;
    logic       a_found;
    logic       b_found;

    assign idx_a      = tile_index(ah, av, HMAXTILE);
    assign idx_b      = tile_index(bh, bv, HMAXTILE);
    assign a_in_range = (ah <= HMAX4) && (av <= VMAX4);
    assign b_in_range = (bh <= HMAX4) && (bv <= VMAX4);

    // A tile is refused while any live bomb sits on it or any blast covers it.
    assign want_a = placeA && a_in_range && !bit_at(occ_map | blastMap, idx_a);
    assign want_b = placeB && b_in_range && !bit_at(occ_map | blastMap, idx_b)
                    && !(placeA && ah == bh && av == bv);

    always_comb begin
        alloc_a = '0;
        alloc_b = '0;
        a_found = 1'b0;
        b_found = 1'b0;
        for (int i = 0; i < SLOTS; i++) begin
            if (slot_state[i] == SLOT_IDLE) begin
                if (want_a && !a_found) begin
                    alloc_a[i] = 1'b1;
                    a_found    = 1'b1;
                end else if (want_b && !b_found) begin
                    alloc_b[i] = 1'b1;
                    b_found    = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dropped <= 1'b0;
            hitA    <= 1'b0;
            hitB    <= 1'b0;
        end else begin
            dropped <= (placeA && !a_found) || (placeB && !b_found);
            hitA    <= a_in_range && bit_at(blastMap, idx_a);
            hitB    <= b_in_range && bit_at(blastMap, idx_b);
        end
    end

endmodule

// File: tb/tb_bomb_manager.sv
// Directed bench for bomb_manager with a short fuse (16) and blast (8) window.
module tb_bomb_manager;

    localparam int TILES = 60;

    logic             clk    = 1'b0;
    logic             rst_n  = 1'b1;
    logic             placeA = 1'b0;
    logic             placeB = 1'b0;
    logic [3:0]       ah = 4'd0, av = 4'd0, bh = 4'd15, bv = 4'd15;
    logic [TILES-1:0] walkAble = '1;
    logic [TILES-1:0] bombMap;
    logic [TILES-1:0] blastMap;
    logic             hitA, hitB, dropped;

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;
    logic [0:0] exp_q[$];

    typedef struct {
        string            name;
        int               cyc;
        logic [TILES-1:0] bomb;
        logic [TILES-1:0] blast;
        logic             hit_a;
        logic             hit_b;
        logic             drop;
    } vec_t;
    vec_t vecs[$];

    bomb_manager #(
        .HMAXTILE(9), .VMAXTILE(5), .SLOTS(8),
        .FUSE_CYCLES(16), .BLAST_CYCLES(8), .CNTW(5)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .placeA(placeA), .ah(ah), .av(av),
        .placeB(placeB), .bh(bh), .bv(bv),
        .walkAble(walkAble),
        .bombMap(bombMap), .blastMap(blastMap),
        .hitA(hitA), .hitB(hitB), .dropped(dropped)
    );

    // clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, got no end, required end of test");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [TILES-1:0] b(input int i);
        return TILES'(1) << i;
    endfunction

    // scoreboard
    task automatic chkm(input string name, input logic [TILES-1:0] act, input logic [TILES-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b required %b", name, act, exp);
        end
    endtask

    // drivers
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) step();
    endtask

    task automatic place(input logic pa, input logic [3:0] h_a, input logic [3:0] v_a,
                         input logic pb, input logic [3:0] h_b, input logic [3:0] v_b);
        placeA = pa; ah = h_a; av = v_a;
        placeB = pb; bh = h_b; bv = v_b;
        step();
        placeA = 1'b0;
        placeB = 1'b0;
    endtask

    task automatic do_reset();
        placeA = 1'b0;
        placeB = 1'b0;
        rst_n  = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        cyc   = 0;
    endtask

    task automatic add(input string n, input int c, input logic [TILES-1:0] bm,
                       input logic [TILES-1:0] bl, input logic ha, input logic hb, input logic d);
        vec_t v;
        v.name = n; v.cyc = c; v.bomb = bm; v.blast = bl;
        v.hit_a = ha; v.hit_b = hb; v.drop = d;
        vecs.push_back(v);
    endtask

    task automatic run_vecs();
        foreach (vecs[i]) begin
            wait_until(vecs[i].cyc);
            chkm({vecs[i].name, "_bomb"},  bombMap,  vecs[i].bomb);
            chkm({vecs[i].name, "_blast"}, blastMap, vecs[i].blast);
            chk1({vecs[i].name, "_hitA"},  hitA,     vecs[i].hit_a);
            chk1({vecs[i].name, "_hitB"},  hitB,     vecs[i].hit_b);
            chk1({vecs[i].name, "_drop"},  dropped,  vecs[i].drop);
        end
        vecs.delete();
    endtask

    logic [TILES-1:0] p1, p2, pa, pb, pool;

    initial begin
        #2 rst_n = 1'b0;
        #3;
        chkm("rst_bomb", bombMap, '0);
        chkm("rst_blast", blastMap, '0);
        chk1("rst_hitA", hitA, 1'b0);
        chk1("rst_hitB", hitB, 1'b0);
        chk1("rst_drop", dropped, 1'b0);

        // single bomb at (3,2): fuse cycles 1..16, blast 17..24
        do_reset();
        p1 = b(13) | b(22) | b(23) | b(24) | b(33);
        add("single_c1",  1,  b(23), '0, 1'b0, 1'b0, 1'b0);
        add("single_c16", 16, b(23), '0, 1'b0, 1'b0, 1'b0);
        add("single_c17", 17, '0,    p1, 1'b0, 1'b0, 1'b0);
        add("single_c18", 18, '0,    p1, 1'b1, 1'b0, 1'b0);
        add("single_c24", 24, '0,    p1, 1'b1, 1'b0, 1'b0);
        add("single_c25", 25, '0,    '0, 1'b1, 1'b0, 1'b0);
        add("single_c26", 26, '0,    '0, 1'b0, 1'b0, 1'b0);
        place(1'b1, 4'd3, 4'd2, 1'b0, 4'd15, 4'd15);
        run_vecs();

        // corner (0,0) by B and right edge (9,1) by A in the same cycle
        do_reset();
        p2 = b(0) | b(1) | b(10) | b(19) | b(18) | b(9) | b(29);
        add("edge_c1",  1,  b(19) | b(0), '0, 1'b0, 1'b0, 1'b0);
        add("edge_c16", 16, b(19) | b(0), '0, 1'b0, 1'b0, 1'b0);
        add("edge_c17", 17, '0, p2, 1'b0, 1'b0, 1'b0);
        add("edge_c18", 18, '0, p2, 1'b1, 1'b1, 1'b0);
        add("edge_c26", 26, '0, '0, 1'b0, 1'b0, 1'b0);
        place(1'b1, 4'd9, 4'd1, 1'b1, 4'd0, 4'd0);
        run_vecs();

        // corner with tile 1 blocked
        do_reset();
        walkAble = '1;
        walkAble[1] = 1'b0;
        add("wall_c17", 17, '0, b(0) | b(10), 1'b0, 1'b0, 1'b0);
        add("wall_c18", 18, '0, b(0) | b(10), 1'b0, 1'b1, 1'b0);
        place(1'b0, 4'd9, 4'd1, 1'b1, 4'd0, 4'd0);
        run_vecs();
        walkAble = '1;

        // duplicate placement on (5,5), re-place while armed, place onto blast
        do_reset();
        place(1'b1, 4'd5, 4'd5, 1'b1, 4'd5, 4'd5);
        chk1("dup_drop_c1", dropped, 1'b1);
        chkm("dup_bomb_c1", bombMap, b(55));
        step();
        chk1("dup_drop_c2", dropped, 1'b0);
        wait_until(3);
        place(1'b1, 4'd5, 4'd5, 1'b0, 4'd5, 4'd5);
        chk1("rearm_drop_c4", dropped, 1'b1);
        chkm("rearm_bomb_c4", bombMap, b(55));
        step();
        chk1("rearm_drop_c5", dropped, 1'b0);
        wait_until(17);
        chkm("dup_blast_c17", blastMap, b(45) | b(54) | b(55) | b(56));
        place(1'b0, 4'd5, 4'd5, 1'b1, 4'd4, 4'd5);
        chk1("onblast_drop_c18", dropped, 1'b1);
        chk1("onblast_hitA_c18", hitA, 1'b1);
        chk1("onblast_hitB_c18", hitB, 1'b1);
        chkm("onblast_bomb_c18", bombMap, '0);
        wait_until(26);
        chkm("dup_blast_c26", blastMap, '0);
        chkm("dup_bomb_c26", bombMap, '0);

        // full pool: eight bombs over four cycles, then a ninth request
        do_reset();
        repeat (4) exp_q.push_back(1'b0);
        exp_q.push_back(1'b1);
        for (int k = 0; k < 4; k++) begin
            place(1'b1, 4'(2 * k), 4'd0, 1'b1, 4'(2 * k), 4'd3);
            chk1("pool_drop", dropped, exp_q.pop_front());
        end
        place(1'b1, 4'd7, 4'd4, 1'b0, 4'd6, 4'd3);
        chk1("pool_drop9", dropped, exp_q.pop_front());
        pool = b(0) | b(2) | b(4) | b(6) | b(30) | b(32) | b(34) | b(36);
        chkm("pool_bomb_c5", bombMap, pool);
        wait_until(17);
        chkm("pool_blast_c17", blastMap, b(0) | b(1) | b(10) | b(20) | b(30) | b(31) | b(40));
        chkm("pool_bomb_c17", bombMap, b(2) | b(4) | b(6) | b(32) | b(34) | b(36));
        wait_until(20);
        chkm("pool_blast_c20", blastMap,
             b(0) | b(1) | b(2) | b(3) | b(4) | b(5) | b(6) | b(7) | b(10) | b(12) | b(14) |
             b(16) | b(20) | b(22) | b(24) | b(26) | b(30) | b(31) | b(32) | b(33) | b(34) |
             b(35) | b(36) | b(37) | b(40) | b(42) | b(44) | b(46));
        chkm("pool_bomb_c20", bombMap, '0);
        wait_until(24);
        place(1'b1, 4'd9, 4'd5, 1'b0, 4'd6, 4'd3);
        chk1("pool_freeing_drop_c25", dropped, 1'b1);
        place(1'b1, 4'd9, 4'd5, 1'b0, 4'd6, 4'd3);
        chk1("pool_free_drop_c26", dropped, 1'b0);
        chkm("pool_free_bomb_c26", bombMap, b(59));
        wait_until(28);
        chkm("pool_blast_c28", blastMap, '0);
        chkm("pool_bomb_c28", bombMap, b(59));

        // chain: (4,1) at t=0, (5,1) at t=5 -> second blasts at cycle 18
        do_reset();
        pa = b(14) | b(13) | b(15) | b(4) | b(24);
        pb = b(15) | b(14) | b(16) | b(5) | b(25);
        place(1'b1, 4'd4, 4'd1, 1'b0, 4'd15, 4'd15);
        wait_until(5);
        place(1'b1, 4'd5, 4'd1, 1'b0, 4'd15, 4'd15);
        chkm("chain_bomb_c6", bombMap, b(14) | b(15));
        wait_until(17);
        chkm("chain_bomb_c17", bombMap, b(15));
        chkm("chain_blast_c17", blastMap, pa);
        step();
        chkm("chain_bomb_c18", bombMap, '0);
        chkm("chain_blast_c18", blastMap, pa | pb);
        wait_until(24);
        chkm("chain_blast_c24", blastMap, pa | pb);
        step();
        chkm("chain_blast_c25", blastMap, pb);
        step();
        chkm("chain_blast_c26", blastMap, '0);

        // asynchronous reset mid-fuse, then no blast after release
        do_reset();
        place(1'b1, 4'd3, 4'd2, 1'b0, 4'd15, 4'd15);
        wait_until(8);
        chkm("rstfuse_bomb_pre", bombMap, b(23));
        rst_n = 1'b0;
        #1;
        chkm("rstfuse_bomb", bombMap, '0);
        chkm("rstfuse_blast", blastMap, '0);
        chk1("rstfuse_drop", dropped, 1'b0);
        #2 rst_n = 1'b1;
        wait_until(18);
        chkm("rstfuse_blast_c18", blastMap, '0);
        wait_until(26);
        chkm("rstfuse_blast_c26", blastMap, '0);
        chkm("rstfuse_bomb_c26", bombMap, '0);

        // asynchronous reset mid-blast while player A is being hit
        do_reset();
        place(1'b1, 4'd3, 4'd2, 1'b0, 4'd15, 4'd15);
        wait_until(20);
        chk1("rstblast_hitA_pre", hitA, 1'b1);
        rst_n = 1'b0;
        #1;
        chkm("rstblast_blast", blastMap, '0);
        chk1("rstblast_hitA", hitA, 1'b0);
        #2 rst_n = 1'b1;
        wait_until(30);
        chkm("rstblast_blast_c30", blastMap, '0);

        // report
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
